// File: rtl/uart_crc8_framer_if.sv
// rtl/uart_crc8_framer_if.sv - payload stream and transmitter handshake bundle for the CRC-8 framer
interface uart_crc8_framer_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;
  logic [7:0] tx_data;
  logic       tx_update;
  logic       tx_busy;

  // slave: the framer itself; master: the payload source plus transmitter side
  modport slave (
    input  s_data, s_valid, s_last, tx_busy,
    output s_ready, tx_data, tx_update
  );

  modport master (
    output s_data, s_valid, s_last, tx_busy,
    input  s_ready, tx_data, tx_update
  );
endinterface

// File: rtl/uart_crc8_framer.sv
// rtl/uart_crc8_framer.sv - buffers payload bytes for the 16x UART transmitter and appends a CRC-8 per frame
module uart_crc8_framer #(
  parameter int         DEPTH       = 16,
  parameter logic [7:0] CRC_POLY    = 8'h07,
  parameter logic [7:0] CRC_INIT    = 8'h00,
  parameter int         REQ_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_crc8_framer_if.slave      bus,
  output logic                   frame_done,
  output logic [7:0]             crc_out,
  output logic [$clog2(DEPTH):0] fifo_level
);
  localparam int           AW       = $clog2(DEPTH);
  localparam int           TW       = $clog2(REQ_TIMEOUT);
  localparam logic [AW:0]  FULL_LVL = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, REQ, WAIT, BACKOFF} state_t;
  state_t state, state_next;

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level;
  logic          fifo_empty, fifo_full, push, pop;
  logic [7:0]    crc, tx_data_q;
  logic          crc_pending, is_crc, tx_update_q;
  logic [TW-1:0] timer;
  logic          timer_done, backoff_done;

  function automatic logic [7:0] crc8_step(input logic [7:0] c_in);
    logic [7:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  assign fifo_empty    = (level == '0);
  assign fifo_full     = (level == FULL_LVL);
  assign push          = bus.s_valid & ~fifo_full;
  assign pop           = (state == LOAD) & ~crc_pending;
  assign bus.s_ready   = ~fifo_full;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_update = tx_update_q;
  assign fifo_level    = level;
  assign timer_done    = (timer == TW'(REQ_TIMEOUT - 1));
  assign backoff_done  = (timer == TW'(1));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.s_last, bus.s_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!fifo_empty || crc_pending) state_next = LOAD;
      LOAD:    state_next = REQ;
      REQ: begin
        if (bus.tx_busy)     state_next = WAIT;
        else if (timer_done) state_next = BACKOFF;
      end
      BACKOFF: if (backoff_done) state_next = REQ;
      WAIT: begin
        if (!bus.tx_busy) state_next = (!fifo_empty || crc_pending) ? LOAD : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Timer restarts on every state change, so it serves both the REQ timeout and the BACKOFF length
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if ((state_next != state) || !((state == REQ) || (state == BACKOFF))) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data_q   <= 8'h00;
      tx_update_q <= 1'b0;
      crc         <= CRC_INIT;
      crc_pending <= 1'b0;
      is_crc      <= 1'b0;
      frame_done  <= 1'b0;
      crc_out     <= CRC_INIT;
    end else begin
      tx_update_q <= (state_next == REQ);
      frame_done  <= 1'b0;
      if (state == LOAD) begin
        if (crc_pending) begin
          tx_data_q   <= crc;
          crc         <= CRC_INIT;
          crc_pending <= 1'b0;
          is_crc      <= 1'b1;
        end else begin
          tx_data_q <= mem[rd_ptr][7:0];
          crc       <= crc8_step(crc ^ mem[rd_ptr][7:0]);
          if (mem[rd_ptr][8]) crc_pending <= 1'b1;
        end
      end
      // tx_data still holds the CRC byte while its transmission is in flight
      if ((state == WAIT) && !bus.tx_busy && is_crc) begin
        frame_done <= 1'b1;
        crc_out    <= tx_data_q;
        is_crc     <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_crc8_framer.sv
// tb/tb_uart_crc8_framer.sv - directed bench for uart_crc8_framer with a behavioural transmitter
module tb_uart_crc8_framer;
  localparam int TX_BITS = 20;
  localparam int BOUND   = 5000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_done;
  logic [7:0] crc_out;
  logic [4:0] fifo_level;

  uart_crc8_framer_if bus();

  uart_crc8_framer #(
    .DEPTH(16), .CRC_POLY(8'h07), .CRC_INIT(8'h00), .REQ_TIMEOUT(64)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .frame_done(frame_done), .crc_out(crc_out), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_miss = 0;
  int         fd_cnt = 0;
  int         stab_bad = 0;
  bit         stall = 1'b0;
  logic [7:0] sent_q[$];
  logic [7:0] frame_q[$];
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_crc(input logic [7:0] c_in, input logic [7:0] d);
    logic [7:0] c;
    logic       fb;
    c = c_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
    return c;
  endfunction

  // Transmitter: sees the update rise, busy 3 cycles later, holds busy for the frame
  initial begin
    logic       prev;
    logic       hit_rst;
    logic [7:0] cap;
    prev = 1'b0;
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
      end else if (bus.tx_update && !prev && !stall) begin
        repeat (2) @(negedge clk);
        cap = bus.tx_data;
        sent_q.push_back(cap);
        bus.tx_busy = 1'b1;
        hit_rst = 1'b0;
        repeat (TX_BITS) begin
          @(negedge clk);
          if (rst) hit_rst = 1'b1;
          else if (!hit_rst && bus.tx_data !== cap) stab_bad++;
        end
        bus.tx_busy = 1'b0;
        prev = 1'b1;
      end else begin
        prev = bus.tx_update;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (frame_done === 1'b1) fd_cnt++;
    end
  end

  task automatic push(input logic [7:0] d, input logic l);
    int t;
    t = 0;
    bus.s_data  = d;
    bus.s_last  = l;
    bus.s_valid = 1'b1;
    while (!bus.s_ready && t < BOUND) begin
      @(negedge clk);
      t++;
    end
    check("push_ready", {31'd0, bus.s_ready}, 32'd1);
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic send_frame();
    for (int i = 0; i < frame_q.size(); i++) push(frame_q[i], (i == frame_q.size() - 1));
  endtask

  task automatic expect_out(input string tag, input int fd_target, input logic [7:0] exp_crc);
    int t;
    t = 0;
    while ((sent_q.size() < exp_q.size() || fd_cnt < fd_target) && t < BOUND) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_count"}, sent_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), (i < sent_q.size()) ? {24'd0, sent_q[i]} : 32'hdead, {24'd0, exp_q[i]});
    end
    check({tag, "_frame_done"}, fd_cnt, fd_target);
    check({tag, "_crc_out"}, crc_out, exp_crc);
  endtask

  initial begin
    int         t;
    int         hi;
    int         lo;
    int         bad;
    logic [7:0] c;

    bus.s_data = 8'h00;
    bus.s_valid = 1'b0;
    bus.s_last = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_s_ready", bus.s_ready, 1);
    check("rst_tx_update", bus.tx_update, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_crc_out", crc_out, 8'h00);
    check("rst_fifo_level", fifo_level, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // "123456789" with first-request latency checks
    sent_q.delete();
    push(8'h31, 1'b0);
    check("lat_push", bus.tx_update, 0);
    push(8'h32, 1'b0);
    check("lat_load", bus.tx_update, 0);
    push(8'h33, 1'b0);
    check("lat_req", bus.tx_update, 1);
    for (int b = 8'h34; b <= 8'h39; b++) push(8'(b), (b == 8'h39));
    exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hF4};
    expect_out("check9", 1, 8'hF4);

    sent_q.delete();
    frame_q = '{8'h01};
    send_frame();
    exp_q = '{8'h01, 8'h07};
    expect_out("one01", 2, 8'h07);

    sent_q.delete();
    frame_q = '{8'h00};
    send_frame();
    exp_q = '{8'h00, 8'h00};
    expect_out("one00", 3, 8'h00);

    // 17-byte burst into a stalled transmitter
    stall = 1'b1;
    sent_q.delete();
    exp_q.delete();
    c = 8'h00;
    for (int b = 0; b < 17; b++) begin
      push(8'(8'h40 + b), (b == 16));
      exp_q.push_back(8'(8'h40 + b));
      c = ref_crc(c, 8'(8'h40 + b));
    end
    exp_q.push_back(c);
    check("burst_level", fifo_level, 16);
    check("burst_s_ready", bus.s_ready, 0);
    check("burst_nothing_sent", sent_q.size(), 0);
    stall = 1'b0;
    expect_out("burst", 4, c);

    sent_q.delete();
    frame_q = '{8'hAA, 8'h55};
    send_frame();
    frame_q = '{8'h0F};
    send_frame();
    exp_q = '{8'hAA, 8'h55, 8'h36, 8'h0F, 8'h2D};
    expect_out("two_frames", 6, 8'h2D);

    // Transmitter ignores the request: 64 cycles high, 2 low, high again
    stall = 1'b1;
    sent_q.delete();
    frame_q = '{8'h5A};
    send_frame();
    t = 0;
    while (!bus.tx_update && t < 100) begin
      @(negedge clk);
      t++;
    end
    hi = 0;
    bad = 0;
    while (bus.tx_update && hi < 200) begin
      if (bus.tx_data !== 8'h5A) bad++;
      @(negedge clk);
      hi++;
    end
    lo = 0;
    while (!bus.tx_update && lo < 200) begin
      if (bus.tx_data !== 8'h5A) bad++;
      @(negedge clk);
      lo++;
    end
    check("timeout_high", hi, 64);
    check("backoff_low", lo, 2);
    check("retry_update", bus.tx_update, 1);
    check("retry_data", bus.tx_data, 8'h5A);
    check("timeout_data_stable", bad, 0);
    stall = 1'b0;
    exp_q = '{8'h5A, 8'h81};
    expect_out("timeout", 7, 8'h81);

    // Reset after 3 of 5 bytes have started
    sent_q.delete();
    frame_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    send_frame();
    t = 0;
    while (sent_q.size() < 3 && t < BOUND) begin
      @(negedge clk);
      t++;
    end
    rst = 1'b1;
    #1;
    check("mid_rst_tx_update", bus.tx_update, 0);
    check("mid_rst_s_ready", bus.s_ready, 1);
    check("mid_rst_fifo_level", fifo_level, 0);
    check("mid_rst_tx_data", bus.tx_data, 0);
    check("mid_rst_crc_out", crc_out, 8'h00);
    check("mid_rst_frame_done", frame_done, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (150) @(negedge clk);
    check("mid_rst_sent", sent_q.size(), 3);
    check("mid_rst_no_crc", fd_cnt, 7);

    sent_q.delete();
    frame_q = '{8'hAA, 8'h55};
    send_frame();
    exp_q = '{8'hAA, 8'h55, 8'h36};
    expect_out("after_rst", 8, 8'h36);

    check("tx_data_stable", stab_bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
